// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle signed/unsigned multiply/divide unit writing the HI/LO pair
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_p_q, neg_p_d;
    logic                 neg_r_q, neg_r_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_sh, div_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    assign signed_op = ~op[0];
    assign mag_a = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b = (signed_op && b[WIDTH-1]) ? -b : b;

    // Lower accumulator half holds the multiplier (or dividend) and drains LSB/MSB first.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opb_q};
    assign div_sub  = div_sh - {1'b0, opb_q};
    assign div_next = div_ge ? {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                             : {div_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};

    assign prod_fix = neg_p_q ? -acc_q : acc_q;
    assign quot_fix = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && !flush) begin
                    if (op[1] && (b == '0)) begin
                        dz_d = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        neg_p_d  = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_d  = signed_op & a[WIDTH-1];
                        acc_d    = {{WIDTH{1'b0}}, mag_a};
                        opb_d    = mag_b;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done/div_zero pulse must match the oldest expected response.
    always @(negedge clock) begin
        if (!reset && (done || div_zero)) begin
            exp_t e;
            chk("done_and_dz_exclusive", {63'd0, done & div_zero}, 64'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got done=%0b div_zero=%0b expected none", done, div_zero);
            end else begin
                e = sb.pop_front();
                chk("event_kind", {62'd0, div_zero, done}, e.dz ? 64'd2 : 64'd1);
                chk("hi", {32'd0, hi}, {32'd0, e.hi});
                chk("lo", {32'd0, lo}, {32'd0, e.lo});
            end
        end
    end

    // Called at a negedge; returns at the negedge where the response pulse is visible.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic exp_dz, input logic [31:0] eh, input logic [31:0] el,
                          input int exp_lat, input string name);
        exp_t e;
        int   lat;
        logic got;
        logic busy_seen;
        e.dz = exp_dz;
        e.hi = eh;
        e.lo = el;
        sb.push_back(e);
        op = o;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a = 32'h0;
        b = 32'h0;
        op = 2'b00;
        lat = 0;
        got = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy) busy_seen = 1'b1;
            if (done || div_zero) begin
                got = 1'b1;
                break;
            end
            @(posedge clock);
            lat++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no response expected response after %0d edges", name, exp_lat);
        end else begin
            chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        end
        chk({name, "_busy_seen"}, {63'd0, busy_seen}, {63'd0, !exp_dz});
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_dz",   {63'd0, div_zero}, 64'd0);
        chk("reset_hi",   {32'd0, hi}, 64'd0);
        chk("reset_lo",   {32'd0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, "mult_neg");
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001, 33, "mult_negneg");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33, "multu_max");
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 32'h00000002, 32'h0000000E, 33, "divu_b2b");
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_neg");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 33, "div_ovf");
        run_op(2'b11, 32'h56781234, 32'h00010000, 1'b0, 32'h00001234, 32'h00005678, 33, "divu_setup");
        run_op(2'b10, 32'h00000005, 32'h00000000, 1'b1, 32'h00001234, 32'h00005678, 0, "div_zero");
        repeat (2) @(negedge clock);

        // Flush mid-RUN, with a stray start issued while busy.
        op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("busy_before_flush", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        chk("busy_after_flush", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clock);
        chk("flush_hi_kept", {32'd0, hi}, 64'h1234);
        chk("flush_lo_kept", {32'd0, lo}, 64'h5678);

        // Flush and start together: start is dropped.
        flush = 1'b1; start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
        @(posedge clock);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("flush_start_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clock);

        // Reset in the middle of an operation.
        op = 2'b01; a = 32'd7; b = 32'd7; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_hi",   {32'd0, hi}, 64'd0);
        chk("midreset_lo",   {32'd0, lo}, 64'd0);

        run_op(2'b01, 32'd3, 32'd4, 1'b0, 32'h00000000, 32'h0000000C, 33, "multu_after_reset");
        @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
